// File: rtl/solver_job_loader_pkg.sv
// Shared solver definitions: default widths, loader FSM states and the
// post-start blanking interval applied to the solver's out_ready level.
package solver_job_loader_pkg;

  localparam int unsigned DEF_LIMB_INDEX_BITS = 6;
  localparam int unsigned DEF_LIMB_SIZE_BITS  = 27;
  localparam int unsigned DEF_TAG_BITS        = 16;
  localparam int unsigned ITER_BITS           = 16;

  // solver_out_ready still shows the previous idle level for two cycles after start
  localparam logic [1:0] BLANK_CYCLES = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CFG,
    ST_START,
    ST_RUN
  } loader_state_e;

endpackage

// File: rtl/solver_job_loader_result_buffer.sv
// One-entry valid/ready holding register for {tag, iterations}; a load in the
// same cycle as a pop replaces the entry and keeps it valid.
module solver_result_buffer #(
  parameter int unsigned TAG_BITS  = 16,
  parameter int unsigned ITER_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_load,
  input  logic [TAG_BITS-1:0]  i_tag,
  input  logic [ITER_BITS-1:0] i_iterations,
  input  logic                 i_ready,
  output logic                 o_valid,
  output logic [TAG_BITS-1:0]  o_tag,
  output logic [ITER_BITS-1:0] o_iterations
);

  logic                 r_valid;
  logic [TAG_BITS-1:0]  r_tag;
  logic [ITER_BITS-1:0] r_iterations;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_tag        <= '0;
      r_iterations <= '0;
    end else if (i_load) begin
      r_valid      <= 1'b1;
      r_tag        <= i_tag;
      r_iterations <= i_iterations;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid      = r_valid;
  assign o_tag        = r_tag;
  assign o_iterations = r_iterations;

endmodule

// File: rtl/solver_job_loader.sv
// Front-end of the solver: streams limb-serial jobs into the solver's write
// ports, configures and starts it, then returns {tag, iterations} to a buffer.
module solver_job_loader
  import solver_job_loader_pkg::*;
#(
  parameter int unsigned LIMB_INDEX_BITS = DEF_LIMB_INDEX_BITS,
  parameter int unsigned LIMB_SIZE_BITS  = DEF_LIMB_SIZE_BITS,
  parameter int unsigned TAG_BITS        = DEF_TAG_BITS
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LIMB_SIZE_BITS-1:0]  in_real,
  input  logic [LIMB_SIZE_BITS-1:0]  in_imag,
  input  logic                       in_last,
  input  logic [LIMB_INDEX_BITS-1:0] in_num_limbs,
  input  logic [ITER_BITS-1:0]       in_iter_lim,
  input  logic [TAG_BITS-1:0]        in_tag,
  output logic                       sol_wr_real_en,
  output logic                       sol_wr_imag_en,
  output logic [LIMB_INDEX_BITS-1:0] sol_wr_index,
  output logic [LIMB_SIZE_BITS-1:0]  sol_real_data,
  output logic [LIMB_SIZE_BITS-1:0]  sol_imag_data,
  output logic                       sol_wr_num_limbs_en,
  output logic [LIMB_INDEX_BITS-1:0] sol_num_limbs_data,
  output logic                       sol_wr_iter_lim_en,
  output logic [ITER_BITS-1:0]       sol_iter_lim_data,
  output logic                       sol_start,
  input  logic                       sol_out_ready,
  input  logic [ITER_BITS-1:0]       sol_iterations,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [TAG_BITS-1:0]        res_tag,
  output logic [ITER_BITS-1:0]       res_iterations,
  output logic                       err
);

  localparam int unsigned CW = LIMB_INDEX_BITS + 1;

  loader_state_e r_state, w_state_next;

  logic                       r_in_ready;
  logic [LIMB_INDEX_BITS-1:0] r_beat_cnt;
  logic [LIMB_INDEX_BITS-1:0] r_num_limbs;
  logic [ITER_BITS-1:0]       r_iter_lim;
  logic [TAG_BITS-1:0]        r_tag;
  logic [1:0]                 r_blank;
  logic                       r_err;
  logic                       r_wr_en;
  logic [LIMB_INDEX_BITS-1:0] r_wr_index;
  logic [LIMB_SIZE_BITS-1:0]  r_real_data;
  logic [LIMB_SIZE_BITS-1:0]  r_imag_data;
  logic                       r_cfg_en;
  logic [LIMB_INDEX_BITS-1:0] r_num_limbs_data;
  logic [ITER_BITS-1:0]       r_iter_lim_data;
  logic                       r_start;

  logic                       w_accept;
  logic                       w_first;
  logic [LIMB_INDEX_BITS-1:0] w_k;
  logic [LIMB_INDEX_BITS-1:0] w_k_next;
  logic [LIMB_INDEX_BITS-1:0] w_nl;
  logic [CW-1:0]              w_total;
  logic                       w_drop;
  logic                       w_bad_count;
  logic                       w_res_valid;
  logic                       w_capture;

  assign w_accept = in_valid && r_in_ready;
  assign w_first  = (r_state == ST_IDLE);

  // The first beat's own num_limbs governs its drop decision, before the latch lands
  assign w_k         = w_first ? '0 : r_beat_cnt;
  assign w_nl        = w_first ? in_num_limbs : r_num_limbs;
  assign w_k_next    = (&w_k) ? w_k : w_k + LIMB_INDEX_BITS'(1);
  assign w_total     = {1'b0, w_k} + CW'(1);
  assign w_drop      = (w_k >= w_nl);
  assign w_bad_count = in_last && (w_total != {1'b0, w_nl});

  assign w_capture = (r_state == ST_RUN) && (r_blank == '0) && sol_out_ready &&
                     (!w_res_valid || res_ready);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_accept) w_state_next = in_last ? ST_CFG : ST_LOAD;
      ST_LOAD:  if (w_accept && in_last) w_state_next = ST_CFG;
      ST_CFG:   w_state_next = ST_START;
      ST_START: w_state_next = ST_RUN;
      ST_RUN:   if (w_capture) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Job latches, beat counter and limb write port
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_in_ready  <= 1'b0;
      r_beat_cnt  <= '0;
      r_num_limbs <= '0;
      r_iter_lim  <= '0;
      r_tag       <= '0;
      r_err       <= 1'b0;
      r_wr_en     <= 1'b0;
      r_wr_index  <= '0;
      r_real_data <= '0;
      r_imag_data <= '0;
    end else begin
      r_in_ready <= (w_state_next == ST_IDLE) || (w_state_next == ST_LOAD);
      r_wr_en    <= 1'b0;
      if (w_accept) begin
        if (w_first) begin
          r_num_limbs <= in_num_limbs;
          r_iter_lim  <= in_iter_lim;
          r_tag       <= in_tag;
        end
        r_beat_cnt <= w_k_next;
        if (!w_drop) begin
          r_wr_en     <= 1'b1;
          r_wr_index  <= w_k;
          r_real_data <= in_real;
          r_imag_data <= in_imag;
        end
        if (w_drop || w_bad_count) r_err <= 1'b1;
      end
    end
  end

  // Configuration writes, start pulse and result blanking
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cfg_en         <= 1'b0;
      r_num_limbs_data <= '0;
      r_iter_lim_data  <= '0;
      r_start          <= 1'b0;
      r_blank          <= '0;
    end else begin
      r_cfg_en <= (r_state == ST_CFG);
      r_start  <= (r_state == ST_START);
      if (r_state == ST_CFG) begin
        r_num_limbs_data <= r_num_limbs;
        r_iter_lim_data  <= r_iter_lim;
      end
      if (r_state == ST_START)  r_blank <= BLANK_CYCLES;
      else if (r_blank != '0)   r_blank <= r_blank - 2'd1;
    end
  end

  solver_result_buffer #(
    .TAG_BITS  (TAG_BITS),
    .ITER_BITS (ITER_BITS)
  ) u_result_buffer (
    .clk          (clock),
    .rst_n        (reset),
    .i_load       (w_capture),
    .i_tag        (r_tag),
    .i_iterations (sol_iterations),
    .i_ready      (res_ready),
    .o_valid      (w_res_valid),
    .o_tag        (res_tag),
    .o_iterations (res_iterations)
  );

  assign in_ready            = r_in_ready;
  assign sol_wr_real_en      = r_wr_en;
  assign sol_wr_imag_en      = r_wr_en;
  assign sol_wr_index        = r_wr_index;
  assign sol_real_data       = r_real_data;
  assign sol_imag_data       = r_imag_data;
  assign sol_wr_num_limbs_en = r_cfg_en;
  assign sol_wr_iter_lim_en  = r_cfg_en;
  assign sol_num_limbs_data  = r_num_limbs_data;
  assign sol_iter_lim_data   = r_iter_lim_data;
  assign sol_start           = r_start;
  assign res_valid           = w_res_valid;
  assign err                 = r_err;

endmodule

// File: tb/tb_solver_job_loader.sv
// Directed bench for solver_job_loader: the solver side is driven by hand and
// every expected value below is worked out from the job each test sends.
module tb_solver_job_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_last;
  logic [26:0] in_real, in_imag;
  logic [5:0]  in_num_limbs;
  logic [15:0] in_iter_lim, in_tag;
  logic        sol_wr_real_en, sol_wr_imag_en;
  logic [5:0]  sol_wr_index;
  logic [26:0] sol_real_data, sol_imag_data;
  logic        sol_wr_num_limbs_en;
  logic [5:0]  sol_num_limbs_data;
  logic        sol_wr_iter_lim_en;
  logic [15:0] sol_iter_lim_data;
  logic        sol_start, sol_out_ready;
  logic [15:0] sol_iterations;
  logic        res_valid, res_ready;
  logic [15:0] res_tag, res_iterations;
  logic        err;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clock = ~clock;

  solver_job_loader #(
    .LIMB_INDEX_BITS (6),
    .LIMB_SIZE_BITS  (27),
    .TAG_BITS        (16)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .in_real             (in_real),
    .in_imag             (in_imag),
    .in_last             (in_last),
    .in_num_limbs        (in_num_limbs),
    .in_iter_lim         (in_iter_lim),
    .in_tag              (in_tag),
    .sol_wr_real_en      (sol_wr_real_en),
    .sol_wr_imag_en      (sol_wr_imag_en),
    .sol_wr_index        (sol_wr_index),
    .sol_real_data       (sol_real_data),
    .sol_imag_data       (sol_imag_data),
    .sol_wr_num_limbs_en (sol_wr_num_limbs_en),
    .sol_num_limbs_data  (sol_num_limbs_data),
    .sol_wr_iter_lim_en  (sol_wr_iter_lim_en),
    .sol_iter_lim_data   (sol_iter_lim_data),
    .sol_start           (sol_start),
    .sol_out_ready       (sol_out_ready),
    .sol_iterations      (sol_iterations),
    .res_valid           (res_valid),
    .res_ready           (res_ready),
    .res_tag             (res_tag),
    .res_iterations      (res_iterations),
    .err                 (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick;
    @(negedge clock);
  endtask

  // Present one beat for one cycle; on return the write it caused is visible
  task automatic beat(input logic [26:0] re, input logic [26:0] im, input logic last,
                      input logic [5:0] nl, input logic [15:0] il, input logic [15:0] tag);
    in_valid = 1'b1; in_real = re; in_imag = im; in_last = last;
    in_num_limbs = nl; in_iter_lim = il; in_tag = tag;
    tick;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Solver reports done; wait (bounded) for the result, check it, then pop it
  task automatic finish_job(input string name, input logic [15:0] iters, input logic [15:0] tag);
    sol_out_ready = 1'b1; sol_iterations = iters;
    for (int i = 0; i < 20; i++) begin
      if (res_valid) break;
      tick;
    end
    check({name, "_res_valid"}, 32'(res_valid), 32'd1);
    check({name, "_res_tag"}, 32'(res_tag), 32'(tag));
    check({name, "_res_iter"}, 32'(res_iterations), 32'(iters));
    sol_out_ready = 1'b0;
    res_ready = 1'b1;
    tick;
    res_ready = 1'b0;
    check({name, "_res_popped"}, 32'(res_valid), 32'd0);
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_real = '0; in_imag = '0;
    in_num_limbs = '0; in_iter_lim = '0; in_tag = '0;
    sol_out_ready = 1'b0; sol_iterations = '0; res_ready = 1'b0;
    tick; tick;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_wr_en", 32'(sol_wr_real_en), 32'd0);
    check("rst_start", 32'(sol_start), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    reset = 1'b1;
    tick; tick;
    check("idle_in_ready", 32'(in_ready), 32'd1);

    // 1) two-limb job; second-beat sideband must be ignored
    beat(27'h1234567, 27'h7FFFFFF, 1'b0, 6'd2, 16'd100, 16'h0042);
    check("t1_wr0_en", 32'({sol_wr_real_en, sol_wr_imag_en}), 32'd3);
    check("t1_wr0_idx", 32'(sol_wr_index), 32'd0);
    check("t1_wr0_real", 32'(sol_real_data), 32'h1234567);
    check("t1_wr0_imag", 32'(sol_imag_data), 32'h7FFFFFF);
    beat(27'h0000055, 27'h00000AA, 1'b1, 6'd7, 16'd9, 16'hDEAD);
    check("t1_wr1_en", 32'(sol_wr_real_en), 32'd1);
    check("t1_wr1_idx", 32'(sol_wr_index), 32'd1);
    check("t1_wr1_real", 32'(sol_real_data), 32'h55);
    check("t1_in_ready_cfg", 32'(in_ready), 32'd0);
    tick;
    check("t1_cfg_en", 32'({sol_wr_num_limbs_en, sol_wr_iter_lim_en}), 32'd3);
    check("t1_cfg_nl", 32'(sol_num_limbs_data), 32'd2);
    check("t1_cfg_il", 32'(sol_iter_lim_data), 32'd100);
    check("t1_no_early_start", 32'(sol_start), 32'd0);
    tick;
    check("t1_start", 32'(sol_start), 32'd1);
    tick;
    check("t1_start_once", 32'(sol_start), 32'd0);
    finish_job("t1", 16'd37, 16'h0042);
    check("t1_err", 32'(err), 32'd0);

    // 2+5) single beat, iter_lim 0, out_ready high from the start pulse on
    beat(27'h0000ABC, 27'h0000DEF, 1'b1, 6'd1, 16'd0, 16'h1111);
    check("t2_wr_idx0", 32'({sol_wr_real_en, sol_wr_index}), 32'h40);
    tick;
    check("t2_cfg_il0", 32'(sol_iter_lim_data), 32'd0);
    check("t2_start_c2", 32'(sol_start), 32'd0);
    tick;
    check("t2_start_c3", 32'(sol_start), 32'd1);
    sol_out_ready = 1'b1; sol_iterations = 16'd5;
    tick;
    check("t5_blank1", 32'(res_valid), 32'd0);
    tick;
    check("t5_blank2", 32'(res_valid), 32'd0);
    tick;
    check("t5_capture", 32'(res_valid), 32'd1);
    finish_job("t2", 16'd5, 16'h1111);

    // 3) three beats for a two-limb job
    beat(27'd1, 27'd2, 1'b0, 6'd2, 16'd50, 16'h0333);
    beat(27'd3, 27'd4, 1'b0, 6'd0, 16'd0, 16'h0000);
    check("t3_wr1_idx", 32'({sol_wr_real_en, sol_wr_index}), 32'h41);
    beat(27'd5, 27'd6, 1'b1, 6'd0, 16'd0, 16'h0000);
    check("t3_drop_no_wr", 32'(sol_wr_real_en), 32'd0);
    check("t3_err", 32'(err), 32'd1);
    tick; tick;
    check("t3_start", 32'(sol_start), 32'd1);
    finish_job("t3", 16'd9, 16'h0333);

    // 4) result A held while job B completes
    beat(27'd7, 27'd8, 1'b1, 6'd1, 16'd10, 16'h00A1);
    tick; tick;
    sol_out_ready = 1'b1; sol_iterations = 16'd11;
    for (int i = 0; i < 20; i++) begin
      if (res_valid) break;
      tick;
    end
    sol_out_ready = 1'b0;
    check("t4_a_valid", 32'(res_valid), 32'd1);
    check("t4_b_in_ready", 32'(in_ready), 32'd1);
    beat(27'd9, 27'd10, 1'b1, 6'd1, 16'd20, 16'h00B2);
    tick; tick;
    check("t4_b_start", 32'(sol_start), 32'd1);
    sol_out_ready = 1'b1; sol_iterations = 16'd22;
    repeat (6) tick;
    check("t4_a_held_tag", 32'(res_tag), 32'h00A1);
    check("t4_a_held_iter", 32'(res_iterations), 32'd11);
    check("t4_stuck_run", 32'(in_ready), 32'd0);
    res_ready = 1'b1;
    tick;
    sol_out_ready = 1'b0;
    check("t4_b_valid", 32'(res_valid), 32'd1);
    check("t4_b_tag", 32'(res_tag), 32'h00B2);
    check("t4_b_iter", 32'(res_iterations), 32'd22);
    tick;
    res_ready = 1'b0;
    check("t4_b_popped", 32'(res_valid), 32'd0);
    check("t4_idle", 32'(in_ready), 32'd1);

    // 6) reset during load
    beat(27'd11, 27'd12, 1'b0, 6'd4, 16'd30, 16'h0666);
    check("t6_wr0", 32'(sol_wr_real_en), 32'd1);
    reset = 1'b0;
    #1;
    check("t6_rst_wr", 32'({sol_wr_real_en, sol_wr_index}), 32'd0);
    check("t6_rst_err", 32'(err), 32'd0);
    check("t6_rst_in_ready", 32'(in_ready), 32'd0);
    tick; tick; tick;
    check("t6_no_start", 32'(sol_start), 32'd0);
    reset = 1'b1;
    tick; tick;
    beat(27'd13, 27'd14, 1'b1, 6'd1, 16'd40, 16'h0077);
    check("t6_fresh_wr", 32'({sol_wr_real_en, sol_wr_index}), 32'h40);
    tick; tick;
    check("t6_fresh_start", 32'(sol_start), 32'd1);
    finish_job("t6", 16'd3, 16'h0077);
    check("t6_err", 32'(err), 32'd0);

    // num_limbs = 0: beat dropped, job still runs
    beat(27'd15, 27'd16, 1'b1, 6'd0, 16'd1, 16'h0000);
    check("nl0_no_wr", 32'(sol_wr_real_en), 32'd0);
    check("nl0_err", 32'(err), 32'd1);
    tick; tick;
    check("nl0_start", 32'(sol_start), 32'd1);
    finish_job("nl0", 16'd1, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
